// File: rtl/pmu_counter_bank.sv
// -----------------------------------------------------------------------------
// pmu_counter_bank
//
// Event counter bank placed directly behind the PMU event crossbar. One
// free-running wrap-around counter per crossbar output, with software preset,
// a bank-wide snapshot into shadow registers, sticky overflow flags and a
// maskable overflow interrupt. Every output is a register.
//
// Ports:
//   clk_i         rising-edge clock for all state
//   rst_i         synchronous active-high reset
//   events_i      per-counter event pulses (crossbar output k -> counter k)
//   en_i          global count enable
//   softrst_i     clears counters, shadows, overflow flags and snap_valid_o
//   wr_en_i       preset strobe; loads wr_data_i into counter wr_idx_i
//   wr_idx_i      preset target (out-of-range indices are ignored)
//   wr_data_i     preset value
//   snap_i        copy all live counters into their shadow registers
//   rd_idx_i      counter to read (out-of-range reads return 0)
//   rd_snap_i     read source: 1 = shadow, 0 = live
//   rd_data_o     registered read data (1-cycle latency)
//   ovf_clr_i     write-1-to-clear for the overflow flags
//   irq_en_i      per-counter interrupt enable
//   ovf_o         sticky overflow flags
//   irq_o         registered overflow interrupt
//   snap_valid_o  set by a snapshot, cleared only by rst_i / softrst_i
// -----------------------------------------------------------------------------
module pmu_counter_bank #(
  parameter int N_COUNTERS = 24,
  parameter int CNT_WIDTH  = 32,
  parameter int IDX_W      = $clog2(N_COUNTERS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_COUNTERS-1:0] events_i,
  input  logic                  en_i,
  input  logic                  softrst_i,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [CNT_WIDTH-1:0]  wr_data_i,
  input  logic                  snap_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  input  logic                  rd_snap_i,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  input  logic [N_COUNTERS-1:0] ovf_clr_i,
  input  logic [N_COUNTERS-1:0] irq_en_i,
  output logic [N_COUNTERS-1:0] ovf_o,
  output logic                  irq_o,
  output logic                  snap_valid_o
);

  // Live counters and their shadow copies.
  logic [CNT_WIDTH-1:0] cnt_q    [N_COUNTERS];
  logic [CNT_WIDTH-1:0] cnt_d    [N_COUNTERS];
  logic [CNT_WIDTH-1:0] shadow_q [N_COUNTERS];
  logic [CNT_WIDTH-1:0] shadow_d [N_COUNTERS];

  logic [N_COUNTERS-1:0] ovf_q, ovf_d;
  logic                  irq_q, irq_d;
  logic                  snap_valid_q, snap_valid_d;
  logic [CNT_WIDTH-1:0]  rd_data_q, rd_data_d;

  // ---------------------------------------------------------------------------
  // Per-counter next-state logic
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_COUNTERS; gi++) begin : g_cnt
    logic wr_hit;
    logic inc;
    logic wrap;

    // An out-of-range wr_idx_i never matches any gi, so it is dropped here.
    assign wr_hit = wr_en_i && (wr_idx_i == IDX_W'(gi));
    assign inc    = en_i && events_i[gi];
    // A preset on the same edge swallows the increment, so it cannot wrap.
    assign wrap   = inc && !wr_hit && (cnt_q[gi] == {CNT_WIDTH{1'b1}});

    assign cnt_d[gi] = softrst_i ? '0 :
                       wr_hit    ? wr_data_i :
                       inc       ? cnt_q[gi] + CNT_WIDTH'(1) :
                                   cnt_q[gi];

    // Wrap dominates a same-edge clear so no overflow is ever lost.
    assign ovf_d[gi] = softrst_i ? 1'b0 :
                       (wrap | (ovf_q[gi] & ~ovf_clr_i[gi]));

    // Shadows capture the pre-update counter value.
    assign shadow_d[gi] = softrst_i ? '0 :
                          snap_i    ? cnt_q[gi] :
                                      shadow_q[gi];
  end

  // ---------------------------------------------------------------------------
  // Bank-wide next-state logic
  // ---------------------------------------------------------------------------
  // Interrupt follows the flag values being written this edge, so it rises
  // together with ovf_o and drops as soon as the last enabled flag clears.
  assign irq_d        = |(ovf_d & irq_en_i);
  assign snap_valid_d = softrst_i ? 1'b0 : (snap_valid_q | snap_i);

  // Read mux over pre-update registers; indices without a counter yield 0.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < N_COUNTERS; i++) begin
      if (rd_idx_i == IDX_W'(i)) begin
        rd_data_d = rd_snap_i ? shadow_q[i] : cnt_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_COUNTERS; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      ovf_q        <= '0;
      irq_q        <= 1'b0;
      snap_valid_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      for (int i = 0; i < N_COUNTERS; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      ovf_q        <= ovf_d;
      irq_q        <= irq_d;
      snap_valid_q <= snap_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rd_data_o    = rd_data_q;
  assign ovf_o        = ovf_q;
  assign irq_o        = irq_q;
  assign snap_valid_o = snap_valid_q;

endmodule

// File: doc/pmu_counter_bank.md
# pmu_counter_bank

Counter bank that sits directly downstream of the PMU event crossbar. It consumes the crossbar's registered per-counter event bits and keeps one free-running event counter per crossbar output. It provides a software preset/read port, a synchronous snapshot of all counters, sticky overflow flags and a maskable overflow interrupt. Counter k counts whichever SoC event the crossbar routes to output k.

## Interface
- N_COUNTERS, 24, number of counters; equals the crossbar output count.
- CNT_WIDTH, 32, bits per counter (>= 2).
- IDX_W, $clog2(N_COUNTERS), derived width of the counter index.

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- events_i  in  N_COUNTERS  bit k = event pulse for counter k (crossbar output k).
- en_i  in  1  global count enable.
- softrst_i  in  1  clear all counters, snapshots and overflow flags.
- wr_en_i  in  1  preset strobe.
- wr_idx_i  in  IDX_W  counter to preset.
- wr_data_i  in  CNT_WIDTH  preset value.
- snap_i  in  1  capture all live counters into shadow registers.
- rd_idx_i  in  IDX_W  counter to read.
- rd_snap_i  in  1  read source: 1 = shadow, 0 = live.
- rd_data_o  out  CNT_WIDTH  registered read data.
- ovf_clr_i  in  N_COUNTERS  write-1-to-clear for the overflow flags.
- irq_en_i  in  N_COUNTERS  per-counter interrupt mask (1 = enabled).
- ovf_o  out  N_COUNTERS  sticky overflow flags.
- irq_o  out  1  registered overflow interrupt.
- snap_valid_o  out  1  set by the first snapshot after a clear.

## Operation
- Counter k increments by 1 on an edge when en_i && events_i[k].
- Wrap: an increment from 2^CNT_WIDTH-1 gives 0 and sets ovf[k]. No saturation.
- Per-counter update priority, highest first:
  - rst_i
  - softrst_i
  - wr_en_i && wr_idx_i==k, which loads wr_data_i; a same-cycle increment is discarded and no overflow is raised
  - increment
- Presets with wr_idx_i >= N_COUNTERS are ignored.
- Overflow flag k:
  - Cleared by rst_i, softrst_i, or ovf_clr_i[k].
  - A wrap on the same edge as ovf_clr_i[k] wins: the flag stays 1.
- Snapshot:
  - snap_i copies every live counter into its shadow register.
  - The captured value is the counter value before that edge's update: increments and presets on the same edge are excluded.
  - snap_valid_o is set on that edge. It is cleared only by rst_i or softrst_i.
- Read:
  - On each edge, rd_data_o <= (rd_snap_i ? shadow : live)[rd_idx_i], using pre-update register values.
  - rd_data_o <= 0 when rd_idx_i >= N_COUNTERS.
- Interrupt: irq_o <= |(ovf_next & irq_en_i), where ovf_next is the flag value being written on the same edge.
- No state machine beyond the per-counter registers. All outputs are registers.

## Timing
- Reset values: all counters, shadows and ovf_o = 0; rd_data_o = 0; irq_o = 0; snap_valid_o = 0. Reset takes effect on the first edge with rst_i=1.
- Count latency: an event at the edge at the end of cycle n is visible in the live counter from cycle n+1.
- Read latency: 1 cycle. An address in cycle n appears on rd_data_o in cycle n+1. If the counter increments on that same edge, the read shows the pre-increment value.
- Overflow latency:
  - The wrap edge sets ovf_o and counter=0 together, both visible the next cycle.
  - irq_o asserts on the same edge, because it is computed from ovf_next.
  - irq_o deasserts on the edge where the last enabled flag clears or irq_en_i drops.
- softrst_i held across several cycles keeps everything at 0. Events during softrst_i are lost.
- rst_i or softrst_i mid-operation: no partial state survives. A snap_i on the same edge is overridden and the shadows become 0.
- Counters are independent. All N_COUNTERS may increment on the same edge.

## Test plan
- Reset, then en_i=1, events_i[3] pulsed 5 cycles, read idx 3 live: rd_data_o=5 one cycle after the address; all other counters read 0.
- Preset counter 0 to 2^CNT_WIDTH-2, then 2 events on counter 0, irq_en_i[0]=1:
  - counter reads 0; ovf_o[0]=1; irq_o=1
  - ovf_clr_i[0] pulse → both deasserted next cycle
  - wrap concurrent with ovf_clr_i[0] → flag remains 1
- Counter 5 = 10 with an event on the same edge as snap_i:
  - shadow 5 reads 10; live counter 5 reads 11; snap_valid_o=1
  - softrst_i → shadow, live and snap_valid_o all 0
- wr_en_i to idx 2 with value 100 on the same edge as an event on counter 2 → counter 2 reads 100. Also: wr_idx_i = N_COUNTERS causes no change; rd_idx_i = N_COUNTERS returns 0.
- en_i=0 with all events_i high for 10 cycles → every counter remains unchanged.
- All events high for 3 cycles with rst_i asserted in cycle 2 → all counters 0 after that edge, then increment from 0 on the remaining cycle.
